instr_fetch_unit: RTL and testbench

Instruction fetch unit: generates sequential PCs, issues word fetches to instruction memory over a valid/ready request channel, buffers returned words in a small in-order prefetch queue, and presents `{pc, instr}` to `main_decoder` through a valid/ready handshake. It is the producer side of the decode interface. It accepts redirects, such as taken branches or jumps resolved downstream, and flushes all wrong-path state.

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: sequential PCs, credit-limited imem requests and an in-order prefetch
// queue presenting {pc, instr} to decode. Define FETCH_BYPASS_EN for the zero-latency response path.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);
    localparam int          AW    = $clog2(DEPTH);
    localparam int          CW    = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    // Both channels: a beat transfers on a cycle where valid & ready are high at the rising edge.
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_q_instr [DEPTH];
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_sh_pc   [DEPTH];
    logic [AW:0]   r_q_wr;
    logic [AW:0]   r_q_rd;
    logic [AW:0]   r_sh_wr;
    logic [AW:0]   r_sh_rd;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic [AW:0]   w_q_count;
    logic          w_q_empty;
    logic [CW:0]   w_credit_used;
    logic          w_req_fire;
    logic          w_rsp_keep;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_out_after_rsp;

    assign w_q_count      = r_q_wr - r_q_rd;
    assign w_q_empty      = (r_q_wr == r_q_rd);
    assign w_credit_used  = {1'b0, w_q_count} + {1'b0, r_outstanding};
    assign imem_req_valid = rst_n & ~redirect_valid & (w_credit_used < LIMIT);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    // Wrong-path words are dropped while discard is nonzero or during a redirect cycle.
    assign w_rsp_keep = imem_rsp_valid & ~redirect_valid & (r_discard == '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_rsp_keep & w_q_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign dec_valid       = (~w_q_empty | w_bypass) & ~redirect_valid;
    assign w_pop           = dec_valid & dec_ready & ~w_q_empty;
    assign w_push          = w_rsp_keep & ~(w_bypass & dec_ready);
    assign w_out_after_rsp = r_outstanding - CW'(imem_rsp_valid);

    always_comb begin
        dec_instr = '0;
        dec_pc    = '0;
        if (!w_q_empty) begin
            dec_instr = r_q_instr[r_q_rd[AW-1:0]];
            dec_pc    = r_q_pc[r_q_rd[AW-1:0]];
        end else if (w_bypass) begin
            dec_instr = imem_rsp_data;
            dec_pc    = r_sh_pc[r_sh_rd[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_q_wr        <= '0;
            r_q_rd        <= '0;
            r_sh_wr       <= '0;
            r_sh_rd       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_after_rsp + CW'(w_req_fire);
            // The shadow PC queue tracks every in-flight request, including ones to be discarded.
            r_sh_wr       <= r_sh_wr + (AW + 1)'(w_req_fire);
            r_sh_rd       <= r_sh_rd + (AW + 1)'(imem_rsp_valid);
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_discard  <= w_out_after_rsp;
                r_q_rd     <= r_q_wr;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                r_q_wr <= r_q_wr + (AW + 1)'(w_push);
                r_q_rd <= r_q_rd + (AW + 1)'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_sh_pc[r_sh_wr[AW-1:0]] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_instr[r_q_wr[AW-1:0]] <= imem_rsp_data;
            r_q_pc[r_q_wr[AW-1:0]]    <= r_sh_pc[r_sh_rd[AW-1:0]];
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order memory model plus an expected {pc, instr} queue.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

`ifdef FETCH_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    int          n_acc    = 0;
    int          n_dec    = 0;
    logic [31:0] model_pc;
    logic [63:0] exp_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[24:0], 7'h13} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory: in-order, fixed latency per request, no backpressure on responses.
    task automatic mem_drive();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rst_n && (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
    endtask

    task automatic cycle_begin();
        mem_drive();
        #1;
    endtask

    task automatic cycle_end();
        logic [63:0] e;
        if (redirect_valid) begin
            chk("redir_dec_valid", 64'(dec_valid), 64'(0));
            chk("redir_req_valid", 64'(imem_req_valid), 64'(0));
        end
        if (imem_req_valid) chk("req_addr", 64'(imem_req_addr), 64'(model_pc));
        if (dec_valid && dec_ready) begin
            n_dec++;
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL dec_unexpected observed pc=0x%0h instr=0x%0h expected none", dec_pc, dec_instr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("dec_pc_instr", {dec_pc, dec_instr}, e);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(cyc + mem_lat);
            exp_q.push_back({model_pc, instr_of(model_pc)});
            model_pc += 32'd4;
            n_acc++;
        end
        if (redirect_valid) begin
            exp_q.delete();
            model_pc = {redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        cycle_begin();
        cycle_end();
    endtask

    task automatic drain();
        imem_req_ready = 1'b0;
        dec_ready      = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || mem_addr_q.size() != 0); i++) cycle();
        chk("drain_exp_empty", 64'(exp_q.size()), 64'(0));
        cycle_begin();
        chk("drain_idle", 64'(dec_valid), 64'(0));
        cycle_end();
    endtask

    initial begin
        logic [63:0] e_first;
        int          k;
        logic        got;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        model_pc       = RESET_PC;
        @(posedge clk);
        #1;
        repeat (2) cycle();

        // Reset state
        cycle_begin();
        chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
        chk("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
        chk("rst_dec_valid", 64'(dec_valid), 64'(0));
        chk("rst_dec_instr", 64'(dec_instr), 64'(0));
        chk("rst_dec_pc", 64'(dec_pc), 64'(0));
        cycle_end();

        // Stream: first request in the first cycle out of reset
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        cycle_begin();
        chk("first_req_valid", 64'(imem_req_valid), 64'(1));
        chk("first_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
        cycle_end();
        cycle_begin();
        chk("rsp_latency", 64'(dec_valid), 64'(BYPASS));
        cycle_end();
        for (int i = 0; i < 20 && model_pc != 32'h8; i++) cycle();

        // Request stall holds the address
        imem_req_ready = 1'b0;
        repeat (3) begin
            cycle_begin();
            chk("stall_addr", 64'(imem_req_addr), 64'h8);
            cycle_end();
        end
        imem_req_ready = 1'b1;
        repeat (12) cycle();
        drain();
        chk("stream_no_loss", 64'(n_dec), 64'(n_acc));

        // Decode backpressure
        imem_req_ready = 1'b1;
        dec_ready      = 1'b0;
        k = n_acc;
        repeat (10) cycle();
        cycle_begin();
        chk("bp_req_valid", 64'(imem_req_valid), 64'(0));
        chk("bp_accepts", 64'(n_acc - k), 64'(2));
        cycle_end();
        e_first   = (exp_q.size() != 0) ? exp_q[0] : 64'hDEAD_BEEF_DEAD_BEEF;
        dec_ready = 1'b1;
        cycle_begin();
        chk("bp_release_valid", 64'(dec_valid), 64'(1));
        chk("bp_first_pc", 64'(dec_pc), 64'(e_first[63:32]));
        cycle_end();
        drain();
        chk("bp_no_loss", 64'(n_dec), 64'(n_acc));

        // Redirect with two requests in flight
        mem_lat        = 3;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        k = n_acc;
        for (int i = 0; i < 10 && (n_acc - k) < 2; i++) cycle();
        chk("rd_two_inflight", 64'(mem_addr_q.size()), 64'(2));
        mem_lat        = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        cycle();
        redirect_valid = 1'b0;
        cycle_begin();
        chk("rd_next_addr", 64'(imem_req_addr), 64'h100);
        cycle_end();
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            cycle_begin();
            if (dec_valid) begin
                got = 1'b1;
                chk("rd_first_pc", 64'(dec_pc), 64'h100);
            end
            cycle_end();
        end
        chk("rd_first_seen", 64'(got), 64'(1));
        drain();

        // Redirect coincident with a response and a decode-ready entry
        imem_req_ready = 1'b1;
        dec_ready      = 1'b0;
        repeat (2) cycle();
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        cycle_begin();
        chk("coinc_queue_empty", 64'(dec_valid), 64'(0));
        chk("coinc_req_valid", 64'(imem_req_valid), 64'(1));
        chk("coinc_req_addr", 64'(imem_req_addr), 64'h200);
        cycle_end();
        repeat (6) cycle();
        drain();

        // Address wrap past 0xFFFFFFFC with unaligned redirect bits
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        cycle();
        redirect_valid = 1'b0;
        cycle_begin();
        chk("wrap_start_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
        cycle_end();
        repeat (8) cycle();
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
